imem_boot: RTL and testbench

IMEM_BOOT -- requirements
Module: imem_boot

---
 rtl/imem_boot.sv | 106 ++++++++++
 tb/tb_imem_boot.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot.sv
// Byte-loaded instruction memory with a one-cycle registered fetch port.
// state | meaning
// LOAD  | accepting image bytes on the load port, fetch port forced to NOP
// RUN   | image locked, fetches served until the next reset
module imem_boot #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        fetch_en,
  input  logic        stall,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misalign_err,
  output logic        range_err,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        boot_done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {LOAD, RUN} state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  wptr;
  logic           wr_en;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  ra0, ra1, ra2, ra3;
  logic           in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    wr_en     = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          wr_en = 1'b1;
          if (ld_last || (wptr == AW'(DEPTH - 1))) state_nxt = RUN;
        end
      end
      RUN: ;
      default: state_nxt = LOAD;
    endcase
  end

  assign boot_done = (state == RUN);

  // Pointer may wrap on the final byte, but the FSM leaves LOAD on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        wptr <= '0;
    else if (wr_en) wptr <= wptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= ld_byte;
  end

  // Full 32-bit compare so stray upper pc bits are flagged rather than aliased.
  assign in_range = (pc <= 32'(DEPTH - 4));
  assign ra0      = {pc[AW-1:2], 2'b00};
  assign ra1      = {pc[AW-1:2], 2'b01};
  assign ra2      = {pc[AW-1:2], 2'b10};
  assign ra3      = {pc[AW-1:2], 2'b11};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr        <= NOP;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      range_err    <= 1'b0;
    end else if (state == LOAD) begin
      instr        <= NOP;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      range_err    <= 1'b0;
    end else if (!stall) begin
      instr        <= NOP;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      range_err    <= 1'b0;
      if (fetch_en) begin
        if (pc[1:0] != 2'b00) begin
          misalign_err <= 1'b1;
        end else if (!in_range) begin
          range_err <= 1'b1;
        end else begin
          instr       <= {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};
          instr_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_boot.sv
// Scoreboard bench for imem_boot: a 64-byte instance for load/fetch/reset
// scenarios and a 16-byte instance for the fill-to-capacity path.
module tb_imem_boot;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fetch_en, stall, ld_valid, ld_last;
  logic [31:0] pc;
  logic [7:0]  ld_byte;
  logic [31:0] instr;
  logic        instr_valid, misalign_err, range_err, ld_ready, boot_done;

  logic        b_rst, b_fetch_en, b_stall, b_ld_valid, b_ld_last;
  logic [31:0] b_pc;
  logic [7:0]  b_ld_byte;
  logic [31:0] b_instr;
  logic        b_instr_valid, b_misalign_err, b_range_err, b_ld_ready, b_boot_done;

  imem_boot #(.DEPTH(64), .NOP(NOP)) dut_a (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .stall(stall),
    .instr(instr), .instr_valid(instr_valid), .misalign_err(misalign_err),
    .range_err(range_err), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_last(ld_last), .ld_ready(ld_ready), .boot_done(boot_done)
  );

  imem_boot #(.DEPTH(16), .NOP(NOP)) dut_b (
    .clk(clk), .rst(b_rst), .pc(b_pc), .fetch_en(b_fetch_en), .stall(b_stall),
    .instr(b_instr), .instr_valid(b_instr_valid), .misalign_err(b_misalign_err),
    .range_err(b_range_err), .ld_valid(b_ld_valid), .ld_byte(b_ld_byte),
    .ld_last(b_ld_last), .ld_ready(b_ld_ready), .boot_done(b_boot_done)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  ma [64];
  logic [7:0]  mb [64];
  int          wp_a;
  logic [34:0] held_a, held_b, e, got;
  logic [34:0] sb [$];

  // Expected {instr, instr_valid, misalign_err, range_err} for one RUN-state fetch cycle.
  function automatic logic [34:0] model(input logic [7:0] mm [64], input int depth,
                                        input logic [34:0] held, input logic [31:0] p,
                                        input logic en, input logic st);
    int idx;
    if (st) return held;
    if (!en) return {NOP, 3'b000};
    if (p[1:0] != 2'b00) return {NOP, 3'b010};
    if (p > 32'(depth - 4)) return {NOP, 3'b001};
    idx = int'(p[5:0]);
    return {mm[idx+3], mm[idx+2], mm[idx+1], mm[idx], 3'b100};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_a(input logic [31:0] p, input logic en, input logic st);
    pc = p; fetch_en = en; stall = st;
    held_a = model(ma, 64, held_a, p, en, st);
    sb.push_back(held_a);
    tick();
  endtask

  task automatic step_b(input logic [31:0] p, input logic en, input logic st);
    b_pc = p; b_fetch_en = en; b_stall = st;
    held_b = model(mb, 16, held_b, p, en, st);
    sb.push_back(held_b);
    tick();
  endtask

  task automatic load_a(input logic [7:0] b, input logic last);
    ld_valid = 1'b1; ld_byte = b; ld_last = last;
    ma[wp_a] = b; wp_a++;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; b_rst = 1'b1;
    #2;
    checks++;
    if ({instr, instr_valid, misalign_err, range_err} !== {NOP, 3'b000}) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", {instr, instr_valid, misalign_err, range_err}, {NOP, 3'b000});
    end
    checks++;
    if (ld_ready !== 1'b1 || boot_done !== 1'b0) begin
      errors++; $display("FAIL reset_ld_state ld_ready=%b boot_done=%b exp 1/0", ld_ready, boot_done);
    end
    checks++;
    if (b_ld_ready !== 1'b1 || b_boot_done !== 1'b0 || b_instr !== NOP) begin
      errors++; $display("FAIL reset_b ld_ready=%b boot_done=%b instr=%h exp 1/0/%h", b_ld_ready, b_boot_done, b_instr, NOP);
    end
    tick(); tick();
    rst = 1'b0; b_rst = 1'b0;
    held_a = {NOP, 3'b000}; held_b = {NOP, 3'b000}; wp_a = 0;
  endtask

  task automatic test_load();
    logic [7:0] img [8];
    img = '{8'h93, 8'h02, 8'h80, 8'h00, 8'h13, 8'h03, 8'hf0, 8'h00};
    fetch_en = 1'b1; pc = 32'h0;
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1; ld_byte = img[i]; ld_last = (i == 7);
      ma[wp_a] = img[i]; wp_a++;
      checks++;
      if (ld_ready !== 1'b1 || boot_done !== 1'b0) begin
        errors++; $display("FAIL load_ready byte=%0d ld_ready=%b boot_done=%b exp 1/0", i, ld_ready, boot_done);
      end
      sb.push_back({NOP, 3'b000});
      tick();
      e = sb.pop_front(); got = {instr, instr_valid, misalign_err, range_err};
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL load_fetch_ignored byte=%0d got=%h exp=%h", i, got, e);
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0; fetch_en = 1'b0;
    checks++;
    if (boot_done !== 1'b1 || ld_ready !== 1'b0) begin
      errors++; $display("FAIL boot_done boot_done=%b ld_ready=%b exp 1/0", boot_done, ld_ready);
    end
    step_a(32'h0, 1'b1, 1'b0);
    e = sb.pop_front(); got = {instr, instr_valid, misalign_err, range_err};
    checks++;
    if (got !== e || e !== {32'h00800293, 3'b100}) begin
      errors++; $display("FAIL fetch_pc0 got=%h exp=%h", got, {32'h00800293, 3'b100});
    end
    step_a(32'h4, 1'b1, 1'b0);
    e = sb.pop_front(); got = {instr, instr_valid, misalign_err, range_err};
    checks++;
    if (got !== e || e !== {32'h00f00313, 3'b100}) begin
      errors++; $display("FAIL fetch_pc4 got=%h exp=%h", got, {32'h00f00313, 3'b100});
    end
  endtask

  task automatic test_misalign();
    logic [31:0] pcs [4];
    pcs = '{32'h2, 32'h0, 32'h3d, 32'h1};
    for (int i = 0; i < 4; i++) begin
      step_a(pcs[i], 1'b1, 1'b0);
      e = sb.pop_front(); got = {instr, instr_valid, misalign_err, range_err};
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL misalign pc=%h got=%h exp=%h", pcs[i], got, e);
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] pcs [5];
    logic        ens [5];
    pcs = '{32'h40, 32'h4, 32'h1000_0000, 32'h1000_0000, 32'h44};
    ens = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      step_a(pcs[i], ens[i], 1'b0);
      e = sb.pop_front(); got = {instr, instr_valid, misalign_err, range_err};
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL range pc=%h en=%b got=%h exp=%h", pcs[i], ens[i], got, e);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] pcs [8];
    logic        ens [8];
    logic        sts [8];
    pcs = '{32'h4, 32'h0, 32'h9, 32'h40, 32'h2, 32'h0, 32'h4, 32'h0};
    ens = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    sts = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      step_a(pcs[i], ens[i], sts[i]);
      e = sb.pop_front(); got = {instr, instr_valid, misalign_err, range_err};
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL stall step=%0d pc=%h got=%h exp=%h", i, pcs[i], got, e);
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_fill();
    logic [31:0] pcs [4];
    b_fetch_en = 1'b0; b_stall = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b_ld_valid = 1'b1; b_ld_byte = 8'(i * 17 + 1); b_ld_last = 1'b0;
      mb[i] = 8'(i * 17 + 1);
      checks++;
      if (b_ld_ready !== 1'b1 || b_boot_done !== 1'b0) begin
        errors++; $display("FAIL fill_ready byte=%0d ld_ready=%b boot_done=%b exp 1/0", i, b_ld_ready, b_boot_done);
      end
      tick();
    end
    checks++;
    if (b_ld_ready !== 1'b0 || b_boot_done !== 1'b1) begin
      errors++; $display("FAIL fill_done ld_ready=%b boot_done=%b exp 0/1", b_ld_ready, b_boot_done);
    end
    b_ld_byte = 8'hee;
    tick();
    b_ld_valid = 1'b0;
    pcs = '{32'h0, 32'hc, 32'h10, 32'hd};
    for (int i = 0; i < 4; i++) begin
      step_b(pcs[i], 1'b1, 1'b0);
      e = sb.pop_front(); got = {b_instr, b_instr_valid, b_misalign_err, b_range_err};
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL fill_fetch pc=%h got=%h exp=%h", pcs[i], got, e);
      end
    end
  endtask

  task automatic test_reset_midload();
    rst = 1'b1;
    #1;
    checks++;
    if ({instr, instr_valid, misalign_err, range_err} !== {NOP, 3'b000} || boot_done !== 1'b0 || ld_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_run instr=%h v=%b boot_done=%b ld_ready=%b exp %h/0/0/1", instr, instr_valid, boot_done, ld_ready, NOP);
    end
    tick();
    rst = 1'b0; wp_a = 0; held_a = {NOP, 3'b000}; fetch_en = 1'b0;
    load_a(8'haa, 1'b0); load_a(8'hbb, 1'b0); load_a(8'hcc, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if ({instr, instr_valid, misalign_err, range_err} !== {NOP, 3'b000} || boot_done !== 1'b0 || ld_ready !== 1'b1) begin
      errors++; $display("FAIL reset_midload instr=%h v=%b boot_done=%b ld_ready=%b exp %h/0/0/1", instr, instr_valid, boot_done, ld_ready, NOP);
    end
    tick();
    rst = 1'b0; wp_a = 0;
    load_a(8'h11, 1'b0); load_a(8'h22, 1'b0); load_a(8'h33, 1'b0); load_a(8'h44, 1'b1);
    checks++;
    if (boot_done !== 1'b1) begin
      errors++; $display("FAIL reload_done boot_done=%b exp 1", boot_done);
    end
    step_a(32'h0, 1'b1, 1'b0);
    e = sb.pop_front(); got = {instr, instr_valid, misalign_err, range_err};
    checks++;
    if (got !== e || e !== {32'h44332211, 3'b100}) begin
      errors++; $display("FAIL reload_addr0 got=%h exp=%h", got, {32'h44332211, 3'b100});
    end
  endtask

  initial begin
    rst = 1'b0; pc = '0; fetch_en = 1'b0; stall = 1'b0;
    ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
    b_rst = 1'b0; b_pc = '0; b_fetch_en = 1'b0; b_stall = 1'b0;
    b_ld_valid = 1'b0; b_ld_byte = '0; b_ld_last = 1'b0;
    test_reset();
    test_load();
    test_misalign();
    test_range();
    test_stall();
    test_fill();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
